// File: rtl/fft_sample_loader.sv
// Captures one framed complex-sample stream into the FFT sample RAM, optionally
// in bit-reversed order, with frame-error detection and a one-cycle done pulse.
module fft_sample_loader #(
   parameter int                ADDR_W    = 15,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [3:0]        log2n,
   input  logic              bitrev_en,
   input  logic [31:0]       snk_data,
   input  logic              snk_valid,
   output logic              snk_ready,
   input  logic              snk_sop,
   input  logic              snk_eop,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   output logic              busy,
   output logic              done,
   output logic              frame_err,
   output logic [14:0]       count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_FILL  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [3:0]        r_log2n;
   logic              r_bitrev;
   logic [14:0]       r_last_k;
   logic [14:0]       r_count;
   logic              r_frame_err;
   logic              r_done;
   logic              r_busy;
   logic              r_wr_vld_p1;
   logic [ADDR_W-1:0] r_wr_addr_p1;
   logic [31:0]       r_wr_data_p1;

   logic              w_accept;
   logic              w_log2n_ok;
   logic              w_store;
   logic              w_latch;
   logic [14:0]       w_k;
   logic [14:0]       w_off;
   logic [ADDR_W-1:0] w_addr;
   logic [14:0]       w_count_nxt;
   logic              w_err_nxt;

   // Reverses the low n bits of k; k never has bits set at or above n.
   function automatic logic [14:0] bit_reverse(input logic [14:0] k, input logic [3:0] n);
      logic [14:0] rev;
      for (int i = 0; i < 15; i++) begin
         rev[14 - i] = k[i];
      end
      return rev >> (4'd15 - n);
   endfunction

   assign snk_ready  = (r_state == S_ARMED) || (r_state == S_FILL);
   assign w_accept   = snk_valid & snk_ready;
   assign w_log2n_ok = (log2n >= 4'd3) && (log2n <= 4'd14);
   assign w_k        = snk_sop ? 15'd0 : r_count;
   assign w_off      = r_bitrev ? bit_reverse(w_k, r_log2n) : w_k;
   assign w_addr     = BASE_ADDR + ADDR_W'(w_off);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_store     = 1'b0;
      w_latch     = 1'b0;
      w_count_nxt = r_count;
      w_err_nxt   = r_frame_err;
      if (abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_log2n_ok) begin
                     w_state_nxt = S_ARMED;
                     w_latch     = 1'b1;
                     w_count_nxt = 15'd0;
                     w_err_nxt   = 1'b0;
                  end else begin
                     w_err_nxt   = 1'b1;
                  end
               end
            end
            S_ARMED, S_FILL: begin
               // In ARMED only a sop beat opens the frame; a sop inside FILL resyncs.
               if (w_accept && ((r_state == S_FILL) || snk_sop)) begin
                  w_store     = 1'b1;
                  w_count_nxt = w_k + 15'd1;
                  w_state_nxt = S_FILL;
                  if ((r_state == S_FILL) && snk_sop) begin
                     w_err_nxt = 1'b1;
                  end
                  if (w_k == r_last_k) begin
                     w_state_nxt = S_DONE;
                     if (!snk_eop) begin
                        w_err_nxt = 1'b1;
                     end
                  end else if (snk_eop) begin
                     w_state_nxt = S_IDLE;
                     w_err_nxt   = 1'b1;
                  end
               end
            end
            S_DONE: begin
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Stage p1: registered RAM write and status, one cycle after beat acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_log2n      <= 4'd3;
         r_bitrev     <= 1'b0;
         r_last_k     <= 15'd7;
         r_count      <= 15'd0;
         r_frame_err  <= 1'b0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         r_wr_vld_p1  <= 1'b0;
         r_wr_addr_p1 <= '0;
         r_wr_data_p1 <= 32'd0;
      end else begin
         if (w_latch) begin
            r_log2n  <= log2n;
            r_bitrev <= bitrev_en;
            r_last_k <= (15'd1 << log2n) - 15'd1;
         end
         r_count     <= w_count_nxt;
         r_frame_err <= w_err_nxt;
         r_done      <= (w_state_nxt == S_DONE);
         r_busy      <= (w_state_nxt != S_IDLE);
         r_wr_vld_p1 <= w_store;
         if (w_store) begin
            r_wr_addr_p1 <= w_addr;
            r_wr_data_p1 <= snk_data;
         end
      end
   end

   assign mem_address    = r_wr_addr_p1;
   assign mem_writedata  = r_wr_data_p1;
   assign mem_write      = r_wr_vld_p1;
   assign mem_chipselect = r_wr_vld_p1;
   assign mem_byteenable = 4'hF;
   assign mem_clken      = 1'b1;
   assign busy           = r_busy;
   assign done           = r_done;
   assign frame_err      = r_frame_err;
   assign count          = r_count;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Bench for fft_sample_loader: three instances (bases 0x100, 0x0, 0x7FFC) share
// one stimulus stream; every frame is scored against a beat-level frame model.
module tb_fft_sample_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [3:0]  log2n = 4'd3;
   logic        bitrev_en = 1'b0;
   logic [31:0] snk_data = 32'd0;
   logic        snk_valid = 1'b0;
   logic        snk_sop = 1'b0;
   logic        snk_eop = 1'b0;

   logic        snk_ready [3];
   logic [14:0] mem_address [3];
   logic [3:0]  mem_byteenable [3];
   logic        mem_chipselect [3];
   logic        mem_write [3];
   logic [31:0] mem_writedata [3];
   logic        mem_clken [3];
   logic        busy [3];
   logic        done [3];
   logic        frame_err [3];
   logic [14:0] count [3];

   int bases [3] = '{32'h100, 32'h0, 32'h7FFC};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam logic [14:0] B = (g == 0) ? 15'h0100 : (g == 1) ? 15'h0000 : 15'h7FFC;
      fft_sample_loader #(.ADDR_W(15), .BASE_ADDR(B)) dut (
         .clk(clk), .reset(reset), .start(start), .abort(abort), .log2n(log2n),
         .bitrev_en(bitrev_en), .snk_data(snk_data), .snk_valid(snk_valid),
         .snk_ready(snk_ready[g]), .snk_sop(snk_sop), .snk_eop(snk_eop),
         .mem_address(mem_address[g]), .mem_byteenable(mem_byteenable[g]),
         .mem_chipselect(mem_chipselect[g]), .mem_write(mem_write[g]),
         .mem_writedata(mem_writedata[g]), .mem_clken(mem_clken[g]),
         .busy(busy[g]), .done(done[g]), .frame_err(frame_err[g]), .count(count[g])
      );
   end

   // Write/done logger, sampled on the falling edge.
   int          cyc = 0;
   int          wcnt [3] = '{0, 0, 0};
   int          dcnt [3] = '{0, 0, 0};
   logic [14:0] wadr [3][1024];
   logic [31:0] wdat [3][1024];
   int          wcyc [3][1024];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (mem_write[g] === 1'b1) begin
            if (wcnt[g] < 1024) begin
               wadr[g][wcnt[g]] = mem_address[g];
               wdat[g][wcnt[g]] = mem_writedata[g];
               wcyc[g][wcnt[g]] = cyc;
            end
            wcnt[g]++;
         end
         if (done[g] === 1'b1) dcnt[g]++;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Frame model: tracks what the loader should have stored and flagged.
   bit          m_armed = 0, m_fill = 0, m_err = 0, m_br = 0;
   int          m_count = 0, m_n = 8, m_l2 = 3, m_done = 0;
   int          exp_k [$];
   logic [31:0] exp_d [$];
   int          snap_w [3];
   int          snap_d [3];

   function automatic int exp_off(int k, int l2, bit br);
      int r = 0;
      if (!br) return k;
      for (int i = 0; i < l2; i++) r = r * 2 + ((k >> i) & 1);
      return r;
   endfunction

   function automatic logic [14:0] exp_addr(int g, int k);
      return 15'((bases[g] + exp_off(k, m_l2, m_br)) % 32768);
   endfunction

   task automatic take_snap();
      for (int g = 0; g < 3; g++) begin
         snap_w[g] = wcnt[g];
         snap_d[g] = dcnt[g];
      end
      exp_k.delete();
      exp_d.delete();
      m_done = 0;
   endtask

   task automatic model_beat(input bit sop, input bit eop, input logic [31:0] d);
      int k;
      if (!(m_armed || m_fill)) return;
      if (m_armed && !sop) return;
      if (m_fill && sop) m_err = 1;
      k = sop ? 0 : m_count;
      exp_k.push_back(k);
      exp_d.push_back(d);
      m_count = k + 1;
      m_armed = 0;
      m_fill  = 1;
      if (k == m_n - 1) begin
         m_fill = 0;
         m_done++;
         if (!eop) m_err = 1;
      end else if (eop) begin
         m_fill = 0;
         m_err  = 1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(input int l2, input bit br);
      start = 1'b1;
      log2n = 4'(l2);
      bitrev_en = br;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (l2 >= 3 && l2 <= 14) begin
         m_armed = 1; m_fill = 0; m_n = 1 << l2; m_l2 = l2; m_br = br;
         m_count = 0; m_err = 0;
      end else begin
         m_err = 1;
      end
   endtask

   task automatic beat(input bit sop, input bit eop, input logic [31:0] d, input bit st);
      snk_valid = 1'b1; snk_sop = sop; snk_eop = eop; snk_data = d; start = st;
      @(posedge clk);
      #1;
      snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0; start = 1'b0;
      model_beat(sop, eop, d);
   endtask

   task automatic abort_beat(input logic [31:0] d, output int acyc);
      acyc = cyc;
      abort = 1'b1; snk_valid = 1'b1; snk_sop = 1'b0; snk_eop = 1'b0; snk_data = d;
      @(posedge clk);
      #1;
      abort = 1'b0; snk_valid = 1'b0;
      m_armed = 0;
      m_fill  = 0;
   endtask

   task automatic check_frame(input string tag);
      int nw;
      idle(3);
      for (int g = 0; g < 3; g++) begin
         nw = wcnt[g] - snap_w[g];
         chk($sformatf("%s_nwrites_u%0d", tag, g), nw, exp_k.size());
         for (int i = 0; i < exp_k.size() && i < nw && snap_w[g] + i < 1024; i++) begin
            chk($sformatf("%s_addr_u%0d_w%0d", tag, g, i), wadr[g][snap_w[g] + i], exp_addr(g, exp_k[i]));
            chk($sformatf("%s_data_u%0d_w%0d", tag, g, i), wdat[g][snap_w[g] + i], exp_d[i]);
         end
         chk($sformatf("%s_done_u%0d", tag, g), dcnt[g] - snap_d[g], m_done);
         chk($sformatf("%s_frame_err_u%0d", tag, g), frame_err[g], m_err);
         chk($sformatf("%s_count_u%0d", tag, g), count[g], m_count);
         chk($sformatf("%s_busy_u%0d", tag, g), busy[g], 0);
      end
      take_snap();
   endtask

   int br_exp [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
   int s0, s1, s2, acyc, l2, fault, n, sent, guard, early_at, rs_at, ab_at, nk;
   bit sop, eop;

   initial begin
      #2 reset = 1'b1;
      idle(3);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("rst_ready_u%0d", g), snk_ready[g], 0);
         chk($sformatf("rst_write_u%0d", g), mem_write[g], 0);
         chk($sformatf("rst_cs_u%0d", g), mem_chipselect[g], 0);
         chk($sformatf("rst_done_u%0d", g), done[g], 0);
         chk($sformatf("rst_busy_u%0d", g), busy[g], 0);
         chk($sformatf("rst_err_u%0d", g), frame_err[g], 0);
         chk($sformatf("rst_count_u%0d", g), count[g], 0);
         chk($sformatf("rst_addr_u%0d", g), mem_address[g], 0);
         chk($sformatf("rst_wdata_u%0d", g), mem_writedata[g], 0);
         chk($sformatf("rst_be_u%0d", g), mem_byteenable[g], 4'hF);
         chk($sformatf("rst_clken_u%0d", g), mem_clken[g], 1);
      end
      reset = 1'b0;
      idle(2);
      take_snap();

      // Normal N=8 capture; a stray start mid-frame must be ignored.
      do_start(3, 0);
      chk("armed_ready", snk_ready[0], 1);
      chk("armed_busy", busy[0], 1);
      for (int k = 0; k < 8; k++) beat(k == 0, k == 7, 32'hA0 + 32'(k), k == 3);
      s0 = snap_w[0]; s2 = snap_w[2];
      check_frame("normal");
      chk("normal_back_to_back", wcyc[0][s0 + 7] - wcyc[0][s0], 7);
      chk("normal_addr0", wadr[0][s0], 15'h100);
      chk("normal_addr7", wadr[0][s0 + 7], 15'h107);
      chk("wrap_addr0", wadr[2][s2], 15'h7FFC);
      chk("wrap_addr3", wadr[2][s2 + 3], 15'h7FFF);
      chk("wrap_addr4", wadr[2][s2 + 4], 15'h0000);
      chk("wrap_addr7", wadr[2][s2 + 7], 15'h0003);

      // Bit-reversed store order.
      do_start(3, 1);
      for (int k = 0; k < 8; k++) beat(k == 0, k == 7, $urandom, 0);
      s1 = snap_w[1];
      check_frame("bitrev");
      for (int k = 0; k < 8; k++) chk($sformatf("bitrev_base0_w%0d", k), wadr[1][s1 + k], 15'(br_exp[k]));

      // Non-sop beats while armed are dropped; abort returns to idle.
      do_start(3, 0);
      for (int k = 0; k < 3; k++) beat(0, 0, $urandom, 0);
      idle(2);
      chk("armed_junk_nowrite", wcnt[0] - snap_w[0], 0);
      chk("armed_junk_still_busy", busy[0], 1);
      abort = 1'b1;
      idle(1);
      abort = 1'b0;
      m_armed = 0;
      check_frame("armed_junk");

      // Early eop on beat 4.
      do_start(3, 0);
      for (int k = 0; k < 5; k++) beat(k == 0, k == 4, $urandom, 0);
      check_frame("early_eop");

      // Missing eop at k=7.
      do_start(3, 0);
      for (int k = 0; k < 8; k++) beat(k == 0, 0, $urandom, 0);
      check_frame("missing_eop");

      // Throttled N=16 stream.
      do_start(4, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 16; k++) begin
         beat(k == 0, k == 15, $urandom, 0);
         idle(1);
      end
      check_frame("throttled");

      // Abort at k=5: the write of beat 4 lands in the abort cycle.
      do_start(4, 0);
      for (int k = 0; k < 5; k++) beat(k == 0, 0, $urandom, 0);
      abort_beat($urandom, acyc);
      chk("abort_idle_busy", busy[0], 0);
      chk("abort_idle_ready", snk_ready[0], 0);
      s0 = snap_w[0];
      check_frame("abort");
      chk("abort_last_write_cycle", wcyc[0][s0 + 4], acyc);

      // Illegal sizes.
      do_start(15, 0);
      chk("bad15_ready", snk_ready[0], 0);
      check_frame("bad_log2n15");
      do_start(2, 1);
      check_frame("bad_log2n2");

      // Asynchronous reset mid-FILL with a write pending.
      do_start(3, 0);
      beat(1, 0, $urandom, 0);
      beat(0, 0, $urandom, 0);
      snk_valid = 1'b1; snk_sop = 1'b0; snk_data = $urandom;
      @(posedge clk);
      #1;
      reset = 1'b1;
      snk_valid = 1'b0;
      #1;
      chk("arst_write", mem_write[0], 0);
      chk("arst_cs", mem_chipselect[0], 0);
      chk("arst_busy", busy[0], 0);
      chk("arst_ready", snk_ready[0], 0);
      chk("arst_count", count[0], 0);
      chk("arst_addr", mem_address[0], 0);
      chk("arst_wdata", mem_writedata[0], 0);
      m_armed = 0; m_fill = 0; m_count = 0; m_err = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_frame("arst_mid_fill");

      // Randomized frames with random faults and gaps.
      for (int f = 0; f < 8; f++) begin
         l2 = $urandom_range(3, 5);
         fault = $urandom_range(0, 4);
         n = 1 << l2;
         sent = 0;
         guard = 0;
         early_at = $urandom_range(1, n - 2);
         rs_at = $urandom_range(1, n - 2);
         ab_at = $urandom_range(1, n - 1);
         do_start(l2, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) beat(0, 0, $urandom, 0);
         while ((m_armed || m_fill) && guard < 200) begin
            guard++;
            if (fault == 4 && sent == ab_at) begin
               abort_beat($urandom, acyc);
               break;
            end
            sop = m_armed || (fault == 3 && sent == rs_at);
            nk = sop ? 0 : m_count;
            eop = (nk == n - 1) ? (fault != 2) : (fault == 1 && sent == early_at);
            beat(sop, eop, $urandom, 0);
            sent++;
            if ($urandom_range(0, 2) == 0) idle(1);
         end
         chk($sformatf("rnd%0d_guard", f), guard < 200, 1);
         check_frame($sformatf("rnd%0d", f));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
